// File: rtl/alu_seq_unit_pkg.sv
// Shared definitions for the execute-stage ALU: opcodes, FSM states,
// and the bit positions of the {Z,C,N,V} status nibble.
package alu_seq_unit_pkg;

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_MLA = 4'b1011;

    localparam int ST_Z = 3;
    localparam int ST_C = 2;
    localparam int ST_N = 1;
    localparam int ST_V = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/alu_seq_unit_mul_iter.sv
// Iterative shift-add multiplier for MUL/MLA; retires BITS multiplier
// bits per cycle and holds the product until the top takes it.
module alu_mul_iter #(
    parameter int W    = 32,
    parameter int BITS = 1
) (
    input  logic         i_Clk,
    input  logic         i_Rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         take,
    input  logic         accumulate,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int STEPS = W / BITS;
    localparam int CNT_W = $clog2(STEPS + 1);

    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     acc_q;
    logic [W-1:0]     step;
    logic [CNT_W-1:0] cnt;
    logic             busy;

    always_comb begin
        step = acc_q;
        for (int j = 0; j < BITS; j++) begin
            if (b_q[j]) step = step + (a_q << j);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (abort) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= accumulate ? c : '0;
            cnt   <= CNT_W'(STEPS);
            busy  <= 1'b1;
        end else if (busy) begin
            if (cnt != '0) begin
                acc_q <= step;
                a_q   <= a_q << BITS;
                b_q   <= b_q >> BITS;
                cnt   <= cnt - 1'b1;
            end else if (take) begin
                busy <= 1'b0;
            end
        end
    end

    assign done    = busy & (cnt == '0);
    assign product = acc_q;

endmodule

// File: rtl/alu_seq_unit.sv
// Registered, handshaked execute-stage ALU with optional iterative
// MUL/MLA path, enabled by defining ALU_SEQ_MUL_EN.
module alu_seq_unit
    import alu_seq_unit_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Flush,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic [3:0]            i_Sigs_Control,
    input  logic [DATA_WIDTH-1:0] i_A,
    input  logic [DATA_WIDTH-1:0] i_B,
    input  logic [DATA_WIDTH-1:0] i_C,
    input  logic                  i_Sig_Carry_In,
    output logic                  o_Valid,
    input  logic                  i_Ready,
    output logic [DATA_WIDTH-1:0] o_ALU_Result,
    output logic [3:0]            o_Status
);

    localparam int W = DATA_WIDTH;

    state_t       state;
    logic         accept;
    logic         slot_free;
    logic [W-1:0] bop;
    logic         cin;
    logic [W:0]   sum;
    logic [W-1:0] alu_res;
    logic         alu_c;
    logic         alu_v;
    logic [3:0]   alu_st;
    logic         is_mul;
    logic         mul_take;
    logic [W-1:0] mul_res;
    logic [3:0]   mul_st;

    assign slot_free = !o_Valid | i_Ready;
    assign o_Ready   = (state == IDLE) & slot_free;
    assign accept    = i_Valid & o_Ready;

    // Subtraction reuses the adder as A + ~B + carry.
    always_comb begin
        bop = '0;
        cin = 1'b0;
        unique case (i_Sigs_Control)
            OP_ADD: bop = i_B;
            OP_ADC: begin bop = i_B;  cin = i_Sig_Carry_In; end
            OP_SUB: begin bop = ~i_B; cin = 1'b1;           end
            OP_SBC: begin bop = ~i_B; cin = i_Sig_Carry_In; end
            default: ;
        endcase
    end

    assign sum = {1'b0, i_A} + {1'b0, bop} + {{W{1'b0}}, cin};

    always_comb begin
        alu_res = '0;
        alu_c   = i_Sig_Carry_In;
        alu_v   = 1'b0;
        unique case (i_Sigs_Control)
            OP_MOV: alu_res = i_B;
            OP_MVN: alu_res = ~i_B;
            OP_AND: alu_res = i_A & i_B;
            OP_ORR: alu_res = i_A | i_B;
            OP_EOR: alu_res = i_A ^ i_B;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
                alu_v   = (i_A[W-1] == bop[W-1])
                        & (sum[W-1] != i_A[W-1]);
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        alu_st       = '0;
        alu_st[ST_Z] = (alu_res == '0);
        alu_st[ST_C] = alu_c;
        alu_st[ST_N] = alu_res[W-1];
        alu_st[ST_V] = alu_v;
    end

`ifdef ALU_SEQ_MUL_EN
    logic mul_start;
    logic mul_done;
    logic mul_cin;

    assign is_mul    = (i_Sigs_Control == OP_MUL)
                     | (i_Sigs_Control == OP_MLA);
    assign mul_start = accept & is_mul & !i_Flush;
    assign mul_take  = (state == MUL_RUN) & mul_done & slot_free;

    alu_mul_iter #(
        .W    (W),
        .BITS (MUL_BITS_PER_CYCLE)
    ) u_mul (
        .i_Clk      (i_Clk),
        .i_Rst_n    (i_Rst_n),
        .start      (mul_start),
        .abort      (i_Flush),
        .take       (mul_take),
        .accumulate (i_Sigs_Control == OP_MLA),
        .a          (i_A),
        .b          (i_B),
        .c          (i_C),
        .done       (mul_done),
        .product    (mul_res)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) mul_cin <= 1'b0;
        else if (mul_start) mul_cin <= i_Sig_Carry_In;
    end

    always_comb begin
        mul_st       = '0;
        mul_st[ST_Z] = (mul_res == '0);
        mul_st[ST_C] = mul_cin;
        mul_st[ST_N] = mul_res[W-1];
        mul_st[ST_V] = 1'b0;
    end
`else
    logic unused_c;

    assign unused_c = ^i_C;
    assign is_mul   = 1'b0;
    assign mul_take = 1'b0;
    assign mul_res  = '0;
    assign mul_st   = '0;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state        <= IDLE;
            o_Valid      <= 1'b0;
            o_ALU_Result <= '0;
            o_Status     <= '0;
        end else if (i_Flush) begin
            state   <= IDLE;
            o_Valid <= 1'b0;
        end else if (mul_take) begin
            state        <= IDLE;
            o_Valid      <= 1'b1;
            o_ALU_Result <= mul_res;
            o_Status     <= mul_st;
        end else if (accept & !is_mul) begin
            o_Valid      <= 1'b1;
            o_ALU_Result <= alu_res;
            o_Status     <= alu_st;
        end else begin
            if (accept) state <= MUL_RUN;
            if (o_Valid & i_Ready) o_Valid <= 1'b0;
        end
    end

endmodule
